// File: rtl/regfile_dump_reader.sv
// Register-file dump sequencer: sweeps first..last (wrapping at N-1) through one async read port
// and streams address/data beats on valid/ready. Optional same-edge write bypass: REGDUMP_BYPASS_EN.
module regfile_dump_reader #(
    parameter int N = 64,
    parameter int W = 32,
    parameter int B = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [B-1:0] first_i,
    input  logic [B-1:0] last_i,
    output logic [B-1:0] ra_o,
    input  logic [W-1:0] rd_i,
    input  logic         wen_i,
    input  logic [B-1:0] wa_i,
    input  logic [W-1:0] wd_i,
    output logic [W-1:0] data_o,
    output logic [B-1:0] addr_o,
    output logic         last_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         busy_o,
    output logic         done_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // READ  | capturing one word per free output slot, ra_o walks toward the last address
    // DRAIN | final word captured, waiting for its handshake
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [B-1:0] TOP_ADDR = B'(N - 1);

    state_t       state, state_nx;
    logic [B-1:0] ra_q, ra_nx;
    logic [B-1:0] last_addr_q, last_addr_nx;
    logic [B-1:0] addr_q, addr_nx;
    logic [W-1:0] data_q, data_nx;
    logic         last_beat_q, last_beat_nx;
    logic         valid_q, valid_nx;
    logic         done_q, done_nx;
    logic [W-1:0] cap_data;
    logic         at_last;

`ifdef REGDUMP_BYPASS_EN
    // A write committing on the capture edge would be missed by rd_i, so forward it.
    always_comb begin
        cap_data = rd_i;
        if (wen_i && (wa_i == ra_q)) begin
            cap_data = wd_i;
        end
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{wen_i, wa_i, wd_i};
    assign cap_data     = rd_i;
`endif

    assign at_last = (ra_q == last_addr_q);

    always_comb begin
        state_nx     = state;
        ra_nx        = ra_q;
        last_addr_nx = last_addr_q;
        addr_nx      = addr_q;
        data_nx      = data_q;
        last_beat_nx = last_beat_q;
        valid_nx     = valid_q;
        done_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    last_addr_nx = last_i;
                    ra_nx        = first_i;
                    state_nx     = READ;
                end
            end
            READ: begin
                // Output slot is free when empty or being drained this edge.
                if (!valid_q || ready_i) begin
                    data_nx      = cap_data;
                    addr_nx      = ra_q;
                    valid_nx     = 1'b1;
                    last_beat_nx = at_last;
                    if (at_last) begin
                        state_nx = DRAIN;
                    end else if (ra_q == TOP_ADDR) begin
                        ra_nx = '0;
                    end else begin
                        ra_nx = ra_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && ready_i) begin
                    valid_nx     = 1'b0;
                    last_beat_nx = 1'b0;
                    done_nx      = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ra_q        <= '0;
            last_addr_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            last_beat_q <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            ra_q        <= ra_nx;
            last_addr_q <= last_addr_nx;
            addr_q      <= addr_nx;
            data_q      <= data_nx;
            last_beat_q <= last_beat_nx;
            valid_q     <= valid_nx;
            done_q      <= done_nx;
        end
    end

    assign ra_o    = ra_q;
    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign last_o  = last_beat_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a behavioural register file answers ra_o combinationally,
// beats are logged at the falling edge and compared against hand-derived sweep expectations.
module tb_regfile_dump_reader;
    localparam int N = 64;
    localparam int W = 32;
    localparam int B = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [B-1:0] first_i, last_i, ra_o, wa_i, addr_o;
    logic [W-1:0] rd_i, wd_i, data_o;
    logic         wen_i, last_o, valid_o, ready_i, busy_o, done_o;

    logic [W-1:0] regs [N];
    assign rd_i = regs[ra_o];

    int tests = 0;
    int fails = 0;
    int dc;

    logic [B-1:0] q_a [$];
    logic [W-1:0] q_d [$];
    logic         q_l [$];

    regfile_dump_reader #(.N(N), .W(W), .B(B)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .first_i(first_i), .last_i(last_i),
        .ra_o(ra_o), .rd_i(rd_i), .wen_i(wen_i), .wa_i(wa_i), .wd_i(wd_i),
        .data_o(data_o), .addr_o(addr_o), .last_o(last_o), .valid_o(valid_o),
        .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input logic [B-1:0] f, input logic [B-1:0] l);
        @(negedge clk);
        first_i = f;
        last_i  = l;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Logs every handshake; optionally stalls ready_i after a given handshake count and
    // pulses start_i during the stall. Returns the cycle (negedges after start) done_o shows up.
    task automatic collect(input logic [B-1:0] first, input int stall_after, input int stall_len,
                           input int budget, output int done_cyc);
        int hs;
        int stall_left;
        logic [B-1:0] held_a;
        logic [W-1:0] held_d;
        hs = 0;
        stall_left = 0;
        done_cyc = -1;
        held_a = '0;
        held_d = '0;
        q_a.delete();
        q_d.delete();
        q_l.delete();
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (stall_left > 0) begin
                if (stall_left == stall_len) begin
                    held_a = addr_o;
                    held_d = data_o;
                    chk("stall_addr", addr_o, 64'((int'(first) + hs) % N));
                    start_i = 1'b1;
                    first_i = 6'd40;
                    last_i  = 6'd41;
                end else begin
                    chk("stall_addr_hold", addr_o, held_a);
                    chk("stall_data_hold", data_o, held_d);
                    start_i = 1'b0;
                end
                chk("stall_valid", valid_o, 1);
                ready_i = 1'b0;
                stall_left--;
            end else begin
                ready_i = 1'b1;
                start_i = 1'b0;
            end
            if (valid_o && ready_i) begin
                q_a.push_back(addr_o);
                q_d.push_back(data_o);
                q_l.push_back(last_o);
                hs++;
                if (hs == stall_after) stall_left = stall_len;
            end
        end
        ready_i = 1'b1;
        start_i = 1'b0;
    endtask

    task automatic check_beats(input logic [B-1:0] first, input int m);
        int ea;
        chk("beat_count", q_a.size(), m);
        for (int i = 0; i < q_a.size(); i++) begin
            ea = (int'(first) + i) % N;
            chk("beat_addr", q_a[i], ea);
            chk("beat_data", q_d[i], regs[ea]);
            chk("beat_last", q_l[i], (i == m - 1));
        end
    endtask

    task automatic after_done();
        chk("idle_busy", busy_o, 0);
        chk("idle_valid", valid_o, 0);
        chk("idle_last", last_o, 0);
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        ready_i = 1'b1;
        start_i = 1'b0;
        first_i = '0;
        last_i  = '0;
        wen_i   = 1'b0;
        wa_i    = '0;
        wd_i    = '0;
        for (int i = 0; i < N; i++) regs[i] = W'(i * 3);

        #2;
        chk("rst_ra", ra_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // full range, no backpressure: done after edge k+65
        start_sweep(6'd0, 6'd63);
        chk("t1_busy", busy_o, 1);
        chk("t1_valid_not_yet", valid_o, 0);
        collect(6'd0, 0, 0, 100, dc);
        chk("t1_done_cyc", dc, 65);
        check_beats(6'd0, 64);
        after_done();

        // wrap through 63 -> 0
        start_sweep(6'd62, 6'd1);
        collect(6'd62, 0, 0, 20, dc);
        chk("t2_done_cyc", dc, 5);
        check_beats(6'd62, 4);
        after_done();

        // single word
        regs[5] = 32'hDEADBEEF;
        start_sweep(6'd5, 6'd5);
        collect(6'd5, 0, 0, 10, dc);
        chk("t3_done_cyc", dc, 2);
        check_beats(6'd5, 1);
        after_done();

        // stall after the 3rd beat, with an ignored start pulse
        start_sweep(6'd0, 6'd7);
        collect(6'd0, 3, 3, 40, dc);
        chk("t4_done_cyc", dc, 12);
        check_beats(6'd0, 8);
        after_done();

        // reset mid-sweep aborts with no beat or done
        start_sweep(6'd0, 6'd15);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ra", ra_o, 0);
        chk("abort_data", data_o, 0);
        chk("abort_addr", addr_o, 0);
        chk("abort_last", last_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done_o, 0);
            chk("abort_no_valid", valid_o, 0);
        end
        rst_n = 1'b1;
        start_sweep(6'd8, 6'd9);
        collect(6'd8, 0, 0, 20, dc);
        chk("t5_done_cyc", dc, 3);
        check_beats(6'd8, 2);
        after_done();

        // write landing on the capture edge of addr 2
        regs[2] = 32'h5;
        wen_i = 1'b1;
        wa_i  = 6'd2;
        wd_i  = 32'h1234;
        start_sweep(6'd2, 6'd2);
        collect(6'd2, 0, 0, 10, dc);
        wen_i = 1'b0;
        chk("t6_done_cyc", dc, 2);
        chk("t6_count", q_a.size(), 1);
        if (q_a.size() > 0) begin
            chk("t6_addr", q_a[0], 2);
`ifdef REGDUMP_BYPASS_EN
            chk("t6_data_bypass", q_d[0], 32'h1234);
`else
            chk("t6_data_nobypass", q_d[0], 32'h5);
`endif
        end
        after_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
